// File: rtl/stack_pkg.sv
// Shared FSM state encoding and default sizing for the stacked-chip ID sorter.
// No logic, no latency, no backpressure.
package stack_pkg;
    localparam int N_CHIP_DEF = 4;
    localparam int ID_W_DEF   = 4;
    localparam int PWR_W_DEF  = 4;
    // Wide enough for 8 chips x 16 bits per entry (128 stream bits).
    localparam int BIT_CNT_W  = 8;

    typedef enum logic [2:0] {
        IDLE,
        ASSIGN,
        SORT,
        SHIFT,
        DONE
    } state_t;
endpackage

// File: rtl/cmp_swap.sv
// One compare-exchange cell: higher power ranks first, equal power -> lower ID ranks first.
// Latency: purely combinational.
// Backpressure: none.
module cmp_swap
    import stack_pkg::*;
#(
    parameter int ID_W  = ID_W_DEF,
    parameter int PWR_W = PWR_W_DEF
) (
    input  logic [ID_W-1:0]  a_id,
    input  logic [PWR_W-1:0] a_pwr,
    input  logic [ID_W-1:0]  b_id,
    input  logic [PWR_W-1:0] b_pwr,
    output logic [ID_W-1:0]  hi_id,
    output logic [PWR_W-1:0] hi_pwr,
    output logic [ID_W-1:0]  lo_id,
    output logic [PWR_W-1:0] lo_pwr
);
    logic a_first;

    assign a_first = (a_pwr > b_pwr) || ((a_pwr == b_pwr) && (a_id < b_id));

    assign hi_id  = a_first ? a_id  : b_id;
    assign hi_pwr = a_first ? a_pwr : b_pwr;
    assign lo_id  = a_first ? b_id  : a_id;
    assign lo_pwr = a_first ? b_pwr : a_pwr;
endmodule

// File: rtl/stack_id_sort.sv
// Assigns chip IDs relative to the bottom layer, sorts (ID, power) by power, then streams the result.
// Latency: sort_finish and first stream bit N_CHIP+2 cycles after start is accepted.
// Backpressure: none; start is ignored while busy, the stream cannot be stalled.
module stack_id_sort
    import stack_pkg::*;
#(
    parameter int N_CHIP = N_CHIP_DEF,
    parameter int ID_W   = ID_W_DEF,
    parameter int PWR_W  = PWR_W_DEF
) (
    input  logic                      t_clk,
    input  logic                      rst_n,
    input  logic                      start,
    input  logic [N_CHIP-1:0]         f_layer,
    input  logic [N_CHIP*PWR_W-1:0]   power_value,
    output logic                      busy,
    output logic                      sort_finish,
    output logic [N_CHIP*ID_W-1:0]    chip_id,
    output logic [N_CHIP*ID_W-1:0]    sorted_id,
    output logic [N_CHIP*PWR_W-1:0]   sorted_pwr,
    output logic                      data_out,
    output logic                      data_valid,
    output logic                      err
);
    localparam int EW    = ID_W + PWR_W;
    localparam int TOT   = N_CHIP * EW;
    localparam int STG_W = $clog2(N_CHIP + 1);
    localparam logic [BIT_CNT_W-1:0] LAST_BIT  = BIT_CNT_W'(TOT - 1);
    localparam logic [STG_W-1:0]     LAST_STG  = STG_W'(N_CHIP);

    state_t state, state_nxt;

    logic [N_CHIP-1:0]       fl_q;
    logic [N_CHIP*PWR_W-1:0] pw_q;
    logic                    fl_ok;
    logic [N_CHIP*ID_W-1:0]  id_asg;
    logic [STG_W-1:0]        stage;
    logic [BIT_CNT_W-1:0]    bit_cnt;
    logic [TOT-1:0]          sreg;
    logic [TOT-1:0]          stream;

    logic [ID_W-1:0]  w_id   [N_CHIP];
    logic [PWR_W-1:0] w_pwr  [N_CHIP];
    logic [ID_W-1:0]  nx_id  [N_CHIP];
    logic [PWR_W-1:0] nx_pwr [N_CHIP];
    logic [ID_W-1:0]  hi_id  [N_CHIP-1];
    logic [PWR_W-1:0] hi_pwr [N_CHIP-1];
    logic [ID_W-1:0]  lo_id  [N_CHIP-1];
    logic [PWR_W-1:0] lo_pwr [N_CHIP-1];

    assign fl_ok    = $onehot(fl_q);
    assign busy     = (state != IDLE);
    assign data_out = data_valid & sreg[TOT-1];

    // ID of position i counts upward from the bottom layer p, wrapping around the stack.
    always_comb begin
        int p_pos;
        p_pos  = 0;
        id_asg = '0;
        for (int i = 0; i < N_CHIP; i++) begin
            if (fl_q[i]) p_pos = i;
        end
        for (int i = 0; i < N_CHIP; i++) begin
            id_asg[i*ID_W +: ID_W] = ID_W'((i + N_CHIP - p_pos) % N_CHIP);
        end
    end

    // One cell per adjacent pair; even stages use even-left pairs, odd stages odd-left pairs.
    for (genvar i = 0; i < N_CHIP - 1; i++) begin : g_pair
        cmp_swap #(.ID_W(ID_W), .PWR_W(PWR_W)) u_cmp (
            .a_id   (w_id[i]),
            .a_pwr  (w_pwr[i]),
            .b_id   (w_id[i+1]),
            .b_pwr  (w_pwr[i+1]),
            .hi_id  (hi_id[i]),
            .hi_pwr (hi_pwr[i]),
            .lo_id  (lo_id[i]),
            .lo_pwr (lo_pwr[i])
        );
    end

    always_comb begin
        for (int j = 0; j < N_CHIP; j++) begin
            nx_id[j]  = w_id[j];
            nx_pwr[j] = w_pwr[j];
        end
        for (int i = 0; i < N_CHIP - 1; i++) begin
            if (i[0] == stage[0]) begin
                nx_id[i]    = hi_id[i];
                nx_pwr[i]   = hi_pwr[i];
                nx_id[i+1]  = lo_id[i];
                nx_pwr[i+1] = lo_pwr[i];
            end
        end
    end

    always_comb begin
        stream = '0;
        for (int e = 0; e < N_CHIP; e++) begin
            stream[TOT-1-e*EW -: EW] = {w_id[e], w_pwr[e]};
        end
    end

    always_ff @(posedge t_clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (start) state_nxt = ASSIGN;
            ASSIGN:  state_nxt = fl_ok ? SORT : IDLE;
            SORT:    if (stage == LAST_STG) state_nxt = SHIFT;
            SHIFT:   if (bit_cnt == LAST_BIT) state_nxt = DONE;
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge t_clk or negedge rst_n) begin
        if (!rst_n) begin
            fl_q        <= '0;
            pw_q        <= '0;
            stage       <= '0;
            bit_cnt     <= '0;
            sreg        <= '0;
            chip_id     <= '0;
            sorted_id   <= '0;
            sorted_pwr  <= '0;
            sort_finish <= 1'b0;
            data_valid  <= 1'b0;
            err         <= 1'b0;
            for (int j = 0; j < N_CHIP; j++) begin
                w_id[j]  <= '0;
                w_pwr[j] <= '0;
            end
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        fl_q        <= f_layer;
                        pw_q        <= power_value;
                        sort_finish <= 1'b0;
                        err         <= 1'b0;
                        data_valid  <= 1'b0;
                    end
                end
                ASSIGN: begin
                    if (!fl_ok) begin
                        err <= 1'b1;
                    end else begin
                        chip_id <= id_asg;
                        stage   <= '0;
                        for (int j = 0; j < N_CHIP; j++) begin
                            w_id[j]  <= id_asg[j*ID_W +: ID_W];
                            w_pwr[j] <= pw_q[j*PWR_W +: PWR_W];
                        end
                    end
                end
                SORT: begin
                    if (stage != LAST_STG) begin
                        stage <= stage + 1'b1;
                        for (int j = 0; j < N_CHIP; j++) begin
                            w_id[j]  <= nx_id[j];
                            w_pwr[j] <= nx_pwr[j];
                        end
                    end else begin
                        for (int j = 0; j < N_CHIP; j++) begin
                            sorted_id[j*ID_W +: ID_W]    <= w_id[j];
                            sorted_pwr[j*PWR_W +: PWR_W] <= w_pwr[j];
                        end
                        sort_finish <= 1'b1;
                        sreg        <= stream;
                        data_valid  <= 1'b1;
                        bit_cnt     <= '0;
                    end
                end
                SHIFT: begin
                    if (bit_cnt == LAST_BIT) begin
                        data_valid <= 1'b0;
                        sreg       <= '0;
                    end else begin
                        sreg    <= sreg << 1;
                        bit_cnt <= bit_cnt + 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_stack_id_sort.sv
// Bench for stack_id_sort: directed runs, expected results queued at issue, checked by a monitor.
module tb_stack_id_sort;
    localparam int N = 4;

    logic        t_clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic [3:0]  f_layer = '0;
    logic [15:0] power_value = '0;
    logic        busy, sort_finish, data_out, data_valid, err;
    logic [15:0] chip_id, sorted_id, sorted_pwr;

    typedef struct packed {
        logic [15:0] cid;
        logic [15:0] sid;
        logic [15:0] spwr;
    } res_t;

    res_t exp_res[$];
    logic exp_bit[$];
    res_t r;
    int   n_cmp = 0;
    int   n_bad = 0;
    logic sf_prev = 1'b0;

    always #5 t_clk = ~t_clk;

    stack_id_sort #(.N_CHIP(4), .ID_W(4), .PWR_W(4)) dut (
        .t_clk       (t_clk),
        .rst_n       (rst_n),
        .start       (start),
        .f_layer     (f_layer),
        .power_value (power_value),
        .busy        (busy),
        .sort_finish (sort_finish),
        .chip_id     (chip_id),
        .sorted_id   (sorted_id),
        .sorted_pwr  (sorted_pwr),
        .data_out    (data_out),
        .data_valid  (data_valid),
        .err         (err)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, "_chip_id"}, 32'(chip_id), 32'd0);
        chk({tag, "_sorted_id"}, 32'(sorted_id), 32'd0);
        chk({tag, "_sorted_pwr"}, 32'(sorted_pwr), 32'd0);
        chk({tag, "_flags"}, 32'({busy, sort_finish, data_out, data_valid, err}), 32'd0);
    endtask

    task automatic push_exp(input logic [15:0] cid, input logic [15:0] sid,
                            input logic [15:0] spwr, input logic [31:0] strm);
        exp_res.push_back('{cid, sid, spwr});
        for (int b = 31; b >= 0; b--) exp_bit.push_back(strm[b]);
    endtask

    task automatic wait_idle(input string tag);
        int t;
        t = 0;
        while (busy && t < 200) begin
            @(posedge t_clk); #1;
            t++;
        end
        chk({tag, "_timeout"}, 32'(t < 200), 32'd1);
    endtask

    // Full run with timing checks; inputs are scrambled right after capture.
    task automatic run_one(input logic [3:0] fl, input logic [15:0] pw, input bit pulse_mid,
                           input logic [15:0] cid, input logic [15:0] sid,
                           input logic [15:0] spwr, input logic [31:0] strm);
        push_exp(cid, sid, spwr, strm);
        @(negedge t_clk);
        start = 1'b1; f_layer = fl; power_value = pw;
        @(posedge t_clk); #1;
        start = 1'b0; f_layer = ~fl; power_value = ~pw;
        chk("busy_after_start", 32'(busy), 32'd1);
        chk("finish_cleared", 32'(sort_finish), 32'd0);
        chk("err_cleared", 32'(err), 32'd0);
        for (int j = 1; j <= N + 2; j++) begin
            if (pulse_mid && j == 3) start = 1'b1;
            @(posedge t_clk); #1;
            if (j == 3) start = 1'b0;
            if (j == N + 1) chk("finish_not_yet", 32'(sort_finish), 32'd0);
            if (j == N + 2) chk("finish_rise", 32'(sort_finish), 32'd1);
        end
        wait_idle("run");
        chk("finish_held", 32'(sort_finish), 32'd1);
        @(posedge t_clk); #1;
        chk("idle_stays", 32'(busy), 32'd0);
    endtask

    always @(negedge t_clk) begin
        if (sort_finish && !sf_prev) begin
            if (exp_res.size() == 0) begin
                chk("unexpected_finish", 32'd1, 32'd0);
            end else begin
                r = exp_res.pop_front();
                chk("chip_id", 32'(chip_id), 32'(r.cid));
                chk("sorted_id", 32'(sorted_id), 32'(r.sid));
                chk("sorted_pwr", 32'(sorted_pwr), 32'(r.spwr));
            end
        end
        sf_prev = sort_finish;
        if (data_valid) begin
            if (exp_bit.size() == 0) chk("unexpected_data_valid", 32'd1, 32'd0);
            else chk("stream_bit", 32'(data_out), 32'(exp_bit.pop_front()));
        end else begin
            chk("data_out_idle", 32'(data_out), 32'd0);
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        #12;
        chk_zero("reset");
        @(negedge t_clk); rst_n = 1'b1;
        repeat (3) @(posedge t_clk);
        #1;
        chk("no_run_after_reset", 32'(busy), 32'd0);

        // bottom at pos0, powers {3,9,1,9}
        run_one(4'b0001, 16'h9193, 1'b0, 16'h3210, 16'h2031, 16'h1399, 32'h19390321);
        // bottom at pos2, equal powers; start pulsed mid-sort
        run_one(4'b0100, 16'h5555, 1'b1, 16'h1032, 16'h3210, 16'h5555, 32'h05152535);
        // bottom at pos3, powers {7,2,7,F}
        run_one(4'b1000, 16'hF727, 1'b0, 16'h0321, 16'h2310, 16'h277F, 32'h0F173722);

        // non-one-hot bottom layer
        @(negedge t_clk);
        start = 1'b1; f_layer = 4'b0110; power_value = 16'h1234;
        @(posedge t_clk); #1;
        start = 1'b0;
        @(posedge t_clk); #1;
        chk("err_k1", 32'(err), 32'd1);
        @(posedge t_clk); #1;
        chk("err_k2", 32'(err), 32'd1);
        chk("err_no_finish", 32'(sort_finish), 32'd0);
        chk("err_idle", 32'(busy), 32'd0);
        run_one(4'b0001, 16'h9193, 1'b0, 16'h3210, 16'h2031, 16'h1399, 32'h19390321);

        // start held through a run: restart only after DONE
        push_exp(16'h3210, 16'h2031, 16'h1399, 32'h19390321);
        push_exp(16'h3210, 16'h2031, 16'h1399, 32'h19390321);
        @(negedge t_clk);
        start = 1'b1; f_layer = 4'b0001; power_value = 16'h9193;
        @(posedge t_clk); #1;
        wait_idle("hold1");
        chk("hold_gap", 32'(busy), 32'd0);
        @(posedge t_clk); #1;
        chk("hold_restart", 32'(busy), 32'd1);
        @(negedge t_clk); start = 1'b0;
        #1;
        wait_idle("hold2");

        // reset while bit 10 of the stream is on data_out
        push_exp(16'h3210, 16'h2031, 16'h1399, 32'h19390321);
        @(negedge t_clk);
        start = 1'b1; f_layer = 4'b0001; power_value = 16'h9193;
        @(posedge t_clk); #1;
        start = 1'b0;
        repeat (16) @(posedge t_clk);
        #1;
        chk("shift_running", 32'(data_valid), 32'd1);
        chk("bits_consumed", 32'(exp_bit.size()), 32'd22);
        rst_n = 1'b0;
        #1;
        chk_zero("mid_shift_reset");
        exp_bit.delete();
        repeat (2) @(negedge t_clk);
        rst_n = 1'b1;
        repeat (20) @(posedge t_clk);
        #1;
        chk("post_reset_idle", 32'({busy, data_valid}), 32'd0);

        chk("res_queue_empty", 32'(exp_res.size()), 32'd0);
        chk("bit_queue_empty", 32'(exp_bit.size()), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
